// File: rtl/multi_station_issue_queue_if.sv
// ---------------------------------------------------------------------------
// multi_station_issue_queue_if
// Bundles the issue queue's handshake and data buses so that the queue and
// its producer/consumer share one connection point.
//   id_*   : decode-side allocation request (id_req flows back to decode)
//   lsu_*  : load writeback used to wake up waiting entries
//   iss_*  : issue register contents plus the downstream stall
// master : the decode/LSU/execute environment around the queue
// slave  : the issue queue itself
// ---------------------------------------------------------------------------
interface multi_station_issue_queue_if #(
  parameter int TAG_W     = 2,
  parameter int PAYLOAD_W = 32,
  parameter int REG_W     = 3
);
  logic                 id_feed;
  logic [PAYLOAD_W-1:0] id_payload;
  logic [15:0]          id_pc;
  logic [15:0]          id_k16;
  logic [REG_W-1:0]     id_src_a;
  logic [REG_W-1:0]     id_src_b;
  logic [REG_W:0]       id_dst;
  logic                 id_sf_wr;
  logic                 id_ld;
  logic                 id_st;
  logic                 id_wait_load;
  logic                 id_req;
  logic                 id_flush;

  logic                 lsu_data_wb;
  logic [TAG_W-1:0]     lsu_data_tag;
  logic [15:0]          lsu_data_in;

  logic                 iss_stall;
  logic                 iss_valid;
  logic [TAG_W-1:0]     iss_tag;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [15:0]          iss_pc;
  logic [15:0]          iss_k16;
  logic [15:0]          iss_ld_data;
  logic [REG_W:0]       iss_dst;
  logic                 iss_sf_wr;
  logic                 iss_ld;
  logic                 iss_st;

  modport master (
    output id_feed, id_payload, id_pc, id_k16, id_src_a, id_src_b, id_dst,
           id_sf_wr, id_ld, id_st, id_wait_load, id_flush,
           lsu_data_wb, lsu_data_tag, lsu_data_in, iss_stall,
    input  id_req, iss_valid, iss_tag, iss_payload, iss_pc, iss_k16,
           iss_ld_data, iss_dst, iss_sf_wr, iss_ld, iss_st
  );

  modport slave (
    input  id_feed, id_payload, id_pc, id_k16, id_src_a, id_src_b, id_dst,
           id_sf_wr, id_ld, id_st, id_wait_load, id_flush,
           lsu_data_wb, lsu_data_tag, lsu_data_in, iss_stall,
    output id_req, iss_valid, iss_tag, iss_payload, iss_pc, iss_k16,
           iss_ld_data, iss_dst, iss_sf_wr, iss_ld, iss_st
  );
endinterface

// File: rtl/multi_station_issue_queue.sv
// ---------------------------------------------------------------------------
// multi_station_issue_queue
// DEPTH-entry reservation queue. Entries are allocated lowest-free-first,
// ordered by an age matrix, woken by LSU load writeback, and the oldest
// hazard-free ready entry is moved each cycle into a single issue register.
// Ports:
//   clk   : clock
//   a_rst : synchronous, active-low reset
//   bus   : slave side of multi_station_issue_queue_if (allocation, wakeup,
//           flush, issue register and downstream stall)
// ---------------------------------------------------------------------------
module multi_station_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 2,
  parameter int PAYLOAD_W = 32,
  parameter int REG_W     = 3
) (
  input logic                        clk,
  input logic                        a_rst,
  multi_station_issue_queue_if.slave bus
);

  // Entry storage
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     wait_q, wait_d;
  // older_q[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [DEPTH-1:0]     older_d [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [15:0]          pc_q [DEPTH];
  logic [15:0]          k16_q [DEPTH];
  logic [15:0]          ldData_q [DEPTH];
  logic [REG_W-1:0]     srcA_q [DEPTH];
  logic [REG_W-1:0]     srcB_q [DEPTH];
  logic [REG_W:0]       dst_q [DEPTH];
  logic [DEPTH-1:0]     sfWr_q, ld_q, st_q;

  // Issue register
  logic                 issValid_q;
  logic [TAG_W-1:0]     issTag_q;
  logic [PAYLOAD_W-1:0] issPayload_q;
  logic [15:0]          issPc_q, issK16_q, issLdData_q;
  logic [REG_W:0]       issDst_q;
  logic                 issSfWr_q, issLd_q, issSt_q;

  logic                 allocFound, allocEn, wakeEn, selEn, selFound, doIssue;
  logic [TAG_W-1:0]     allocIdx, selIdx;
  logic [DEPTH-1:0]     eligible;

  // Lowest-index free entry, judged on pre-edge state only.
  always_comb begin
    allocFound = 1'b0;
    allocIdx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        allocFound = 1'b1;
        allocIdx   = TAG_W'(i);
      end
    end
  end

  assign allocEn = bus.id_feed & allocFound & ~bus.id_flush;
  assign wakeEn  = bus.lsu_data_wb & valid_q[bus.lsu_data_tag] & wait_q[bus.lsu_data_tag];
  assign selEn   = ~(issValid_q & bus.iss_stall);

  // An entry is eligible when it is ready and has no register, flag or
  // memory-ordering conflict with any valid entry older than itself.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] & ~wait_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (older_q[i][j] && valid_q[j]) begin
          if (dst_q[j][REG_W] && ((srcA_q[i] == dst_q[j][REG_W-1:0]) ||
                                  (srcB_q[i] == dst_q[j][REG_W-1:0])))
            eligible[i] = 1'b0;
          if (dst_q[i][REG_W] && ((dst_q[i][REG_W-1:0] == srcA_q[j]) ||
                                  (dst_q[i][REG_W-1:0] == srcB_q[j])))
            eligible[i] = 1'b0;
          if (dst_q[i][REG_W] && dst_q[j][REG_W] &&
              (dst_q[i][REG_W-1:0] == dst_q[j][REG_W-1:0]))
            eligible[i] = 1'b0;
          if (sfWr_q[i] && sfWr_q[j])
            eligible[i] = 1'b0;
          if ((ld_q[i] && st_q[j]) || (st_q[i] && (ld_q[j] || st_q[j])))
            eligible[i] = 1'b0;
        end
      end
    end
  end

  // The age matrix totally orders valid entries, so exactly one eligible
  // entry has no eligible elder whenever any entry is eligible.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && ((older_q[i] & eligible) == '0)) begin
        selFound = 1'b1;
        selIdx   = TAG_W'(i);
      end
    end
  end

  assign doIssue = selEn & selFound;

  // The new row is written before the column clears so that an entry
  // issuing on the same edge is not recorded as older than the newcomer.
  always_comb begin
    valid_d = valid_q;
    wait_d  = wait_q;
    for (int k = 0; k < DEPTH; k++) older_d[k] = older_q[k];
    if (allocEn) begin
      valid_d[allocIdx] = 1'b1;
      wait_d[allocIdx]  = bus.id_wait_load;
      older_d[allocIdx] = valid_q;
      for (int k = 0; k < DEPTH; k++) older_d[k][allocIdx] = 1'b0;
    end
    if (doIssue) begin
      valid_d[selIdx] = 1'b0;
      for (int k = 0; k < DEPTH; k++) older_d[k][selIdx] = 1'b0;
    end
    if (wakeEn) wait_d[bus.lsu_data_tag] = 1'b0;
    if (bus.id_flush) begin
      valid_d = '0;
      wait_d  = '0;
      for (int k = 0; k < DEPTH; k++) older_d[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      valid_q <= '0;
      wait_q  <= '0;
      sfWr_q  <= '0;
      ld_q    <= '0;
      st_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        older_q[k]   <= '0;
        payload_q[k] <= '0;
        pc_q[k]      <= '0;
        k16_q[k]     <= '0;
        ldData_q[k]  <= '0;
        srcA_q[k]    <= '0;
        srcB_q[k]    <= '0;
        dst_q[k]     <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wait_q  <= wait_d;
      for (int k = 0; k < DEPTH; k++) older_q[k] <= older_d[k];
      if (allocEn) begin
        payload_q[allocIdx] <= bus.id_payload;
        pc_q[allocIdx]      <= bus.id_pc;
        k16_q[allocIdx]     <= bus.id_k16;
        ldData_q[allocIdx]  <= '0;
        srcA_q[allocIdx]    <= bus.id_src_a;
        srcB_q[allocIdx]    <= bus.id_src_b;
        dst_q[allocIdx]     <= bus.id_dst;
        sfWr_q[allocIdx]    <= bus.id_sf_wr;
        ld_q[allocIdx]      <= bus.id_ld;
        st_q[allocIdx]      <= bus.id_st;
      end
      if (wakeEn && !bus.id_flush) ldData_q[bus.lsu_data_tag] <= bus.lsu_data_in;
    end
  end

  // Flush only guarantees iss_valid; the data fields may stay stale.
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      issValid_q   <= 1'b0;
      issTag_q     <= '0;
      issPayload_q <= '0;
      issPc_q      <= '0;
      issK16_q     <= '0;
      issLdData_q  <= '0;
      issDst_q     <= '0;
      issSfWr_q    <= 1'b0;
      issLd_q      <= 1'b0;
      issSt_q      <= 1'b0;
    end else if (bus.id_flush) begin
      issValid_q <= 1'b0;
    end else if (selEn) begin
      issValid_q <= selFound;
      if (selFound) begin
        issTag_q     <= selIdx;
        issPayload_q <= payload_q[selIdx];
        issPc_q      <= pc_q[selIdx];
        issK16_q     <= k16_q[selIdx];
        issLdData_q  <= ldData_q[selIdx];
        issDst_q     <= dst_q[selIdx];
        issSfWr_q    <= sfWr_q[selIdx];
        issLd_q      <= ld_q[selIdx];
        issSt_q      <= st_q[selIdx];
      end
    end
  end

  assign bus.id_req      = allocFound;
  assign bus.iss_valid   = issValid_q;
  assign bus.iss_tag     = issTag_q;
  assign bus.iss_payload = issPayload_q;
  assign bus.iss_pc      = issPc_q;
  assign bus.iss_k16     = issK16_q;
  assign bus.iss_ld_data = issLdData_q;
  assign bus.iss_dst     = issDst_q;
  assign bus.iss_sf_wr   = issSfWr_q;
  assign bus.iss_ld      = issLd_q;
  assign bus.iss_st      = issSt_q;

endmodule
